// File: rtl/lsu.sv
// Load/store unit: turns EXU result bundles into single-beat bus accesses and produces WBU bundles.
// Optional LSU_MISALIGN_CHECK_EN: traps misaligned H/W accesses locally instead of issuing them.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] pc,
  input  logic [4:0]  rd,
  input  logic        R_wen,
  input  logic        mem_wen,
  input  logic        mem_ren,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs2_value,
  input  logic [31:0] EX_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc_out,
  output logic [4:0]  rd_out,
  output logic        R_wen_out,
  output logic [31:0] wb_data,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t      state, state_nxt;
  logic        fire;
  logic        is_mem;
  logic        mis_in;
  logic [1:0]  off;
  logic [31:0] st_data;
  logic [3:0]  st_mask;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] shifted;
  logic [31:0] ld_data;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;
  assign is_mem   = mem_ren || mem_wen;
  assign off      = EX_result[1:0];

`ifdef LSU_MISALIGN_CHECK_EN
  // funct3[1]=1 covers W and the undefined encodings that behave as W
  assign mis_in = is_mem && (((funct3[1:0] == 2'b01) && off[0]) ||
                             (funct3[1] && (off != 2'b00)));
`else
  assign mis_in = 1'b0;
`endif

  always_comb begin
    st_data = rs2_value;
    st_mask = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_data = {4{rs2_value[7:0]}};
        st_mask = 4'b0001 << off;
      end
      2'b01: begin
        st_data = {2{rs2_value[15:0]}};
        st_mask = 4'b0011 << {off[1], 1'b0};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    ld_data = shifted;
    case (f3_q[1:0])
      2'b00:   ld_data = f3_q[2] ? {24'h0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ld_data = f3_q[2] ? {16'h0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fire && is_mem && !mis_in) state_nxt = BUS;
      BUS:     if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      pc_out    <= '0;
      rd_out    <= '0;
      R_wen_out <= 1'b0;
      wb_data   <= '0;
      misalign  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      f3_q      <= '0;
      off_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            pc_out   <= pc;
            rd_out   <= rd;
            wb_data  <= EX_result;
            misalign <= mis_in;
            if (is_mem && !mis_in) begin
              out_valid <= 1'b0;
              R_wen_out <= R_wen && !mem_wen;
              mem_req   <= 1'b1;
              mem_we    <= mem_wen;
              mem_addr  <= {EX_result[31:2], 2'b00};
              mem_wdata <= st_data;
              mem_wmask <= st_mask;
              f3_q      <= funct3;
              off_q     <= off;
            end else begin
              out_valid <= 1'b1;
              R_wen_out <= R_wen && !mis_in;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        BUS: begin
          // Stores return the original byte address as writeback data
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            out_valid <= 1'b1;
            wb_data   <= mem_we ? {mem_addr[31:2], off_q} : ld_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed, table-driven bench for lsu: vector table plus hand-written backpressure,
// repeated-ack and mid-transaction reset sequences.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [4:0]  rd;
  logic        R_wen;
  logic        mem_wen;
  logic        mem_ren;
  logic [2:0]  funct3;
  logic [31:0] rs2_value;
  logic [31:0] EX_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc_out;
  logic [4:0]  rd_out;
  logic        R_wen_out;
  logic [31:0] wb_data;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .rd(rd), .R_wen(R_wen), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .funct3(funct3), .rs2_value(rs2_value), .EX_result(EX_result),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .rd_out(rd_out),
    .R_wen_out(R_wen_out), .wb_data(wb_data), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    string       name;
    logic        ren;
    logic        wen;
    logic [2:0]  f3;
    logic [31:0] ex;
    logic [31:0] rs2;
    logic [31:0] rdata;
    logic        rwen;
    logic [4:0]  rdi;
    logic [31:0] pcv;
    int          lat;
    logic        bus;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] wb;
    logic        rwen_out;
    logic        mis;
  } vec_t;

  vec_t vecs[13];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_output(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [31:0] ex, input logic [31:0] rs2, input logic rwen,
                       input logic [4:0] rdi, input logic [31:0] pcv);
    mem_ren   = ren;
    mem_wen   = wen;
    funct3    = f3;
    EX_result = ex;
    rs2_value = rs2;
    R_wen     = rwen;
    rd        = rdi;
    pc        = pcv;
    in_valid  = 1'b1;
  endtask

  // Entered just after a falling edge; leaves just after the falling edge where the result is checked
  task automatic apply_stimulus(input vec_t v);
    check_output({v.name, " in_ready"}, in_ready, 1'b1);
    drive(v.ren, v.wen, v.f3, v.ex, v.rs2, v.rwen, v.rdi, v.pcv);
    @(negedge clk);
    in_valid = 1'b0;
    if (v.bus) begin
      check_output({v.name, " mem_req"}, mem_req, 1'b1);
      check_output({v.name, " mem_we"}, mem_we, v.we);
      check32({v.name, " mem_addr"}, mem_addr, v.addr);
      check32({v.name, " mem_wdata"}, mem_wdata, v.wdata);
      check32({v.name, " mem_wmask"}, {28'h0, mem_wmask}, {28'h0, v.mask});
      check_output({v.name, " busy in_ready"}, in_ready, 1'b0);
      check_output({v.name, " busy out_valid"}, out_valid, 1'b0);
      for (int k = 0; k < v.lat; k++) begin
        @(negedge clk);
        check_output({v.name, " wait mem_req"}, mem_req, 1'b1);
        check32({v.name, " wait mem_addr"}, mem_addr, v.addr);
      end
      mem_rdata = v.rdata;
      mem_ack   = 1'b1;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
    end
    check_output({v.name, " done mem_req"}, mem_req, 1'b0);
    check_output({v.name, " out_valid"}, out_valid, 1'b1);
    check32({v.name, " wb_data"}, wb_data, v.wb);
    check32({v.name, " pc_out"}, pc_out, v.pcv);
    check32({v.name, " rd_out"}, {27'h0, rd_out}, {27'h0, v.rdi});
    check_output({v.name, " R_wen_out"}, R_wen_out, v.rwen_out);
    check_output({v.name, " misalign"}, misalign, v.mis);
  endtask

  initial begin
    vecs[0]  = '{"alu0", 1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 32'h0, 1'b1, 5'd5, 32'h100, 0,
                 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_1234, 1'b1, 1'b0};
    vecs[1]  = '{"alu1", 1'b0, 1'b0, 3'b000, 32'hFFFF_0000, 32'h0, 32'h0, 1'b0, 5'd31, 32'h104, 0,
                 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hFFFF_0000, 1'b0, 1'b0};
    vecs[2]  = '{"lb", 1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 1'b1, 5'd10, 32'h108, 3,
                 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b1000, 32'hFFFF_FF80, 1'b1, 1'b0};
    vecs[3]  = '{"lbu", 1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_FFFF, 1'b1, 5'd11, 32'h10C, 3,
                 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'b1000, 32'h0000_0080, 1'b1, 1'b0};
    vecs[4]  = '{"sh", 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'hABCD_1234, 32'h0, 1'b1, 5'd3, 32'h110, 1,
                 1'b1, 1'b1, 32'h0000_0100, 32'h1234_1234, 4'b1100, 32'h0000_0102, 1'b0, 1'b0};
    vecs[5]  = '{"lh", 1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_0000, 1'b1, 5'd12, 32'h114, 2,
                 1'b1, 1'b0, 32'h0, 32'h0, 4'b1100, 32'hFFFF_8001, 1'b1, 1'b0};
    vecs[6]  = '{"lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'h8001_0000, 1'b1, 5'd13, 32'h118, 2,
                 1'b1, 1'b0, 32'h0, 32'h0, 4'b1100, 32'h0000_8001, 1'b1, 1'b0};
    vecs[7]  = '{"lw", 1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b1, 5'd14, 32'h11C, 0,
                 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[8]  = '{"sb", 1'b0, 1'b1, 3'b000, 32'h0000_0021, 32'h0000_00A5, 32'h0, 1'b0, 5'd1, 32'h120, 1,
                 1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 4'b0010, 32'h0000_0021, 1'b0, 1'b0};
    vecs[9]  = '{"sw", 1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 1'b0, 5'd2, 32'h124, 0,
                 1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'b1111, 32'h0000_0040, 1'b0, 1'b0};
    vecs[10] = '{"ld011", 1'b1, 1'b0, 3'b011, 32'h0000_0044, 32'h0, 32'h1234_5678, 1'b1, 5'd15, 32'h128, 1,
                 1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'b1111, 32'h1234_5678, 1'b1, 1'b0};
    vecs[11] = '{"lb_pos", 1'b1, 1'b0, 3'b000, 32'h0000_0001, 32'h0, 32'h0000_7F00, 1'b1, 5'd16, 32'h12C, 2,
                 1'b1, 1'b0, 32'h0, 32'h0, 4'b0010, 32'h0000_007F, 1'b1, 1'b0};
`ifdef LSU_MISALIGN_CHECK_EN
    vecs[12] = '{"lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'hDDCC_BBAA, 1'b1, 5'd17, 32'h130, 1,
                 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0000_0101, 1'b0, 1'b1};
`else
    vecs[12] = '{"lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'hDDCC_BBAA, 1'b1, 5'd17, 32'h130, 1,
                 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'b1111, 32'h00DD_CCBB, 1'b1, 1'b0};
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    in_valid  = 1'b0;

    #12;
    check_output("reset in_ready", in_ready, 1'b1);
    check_output("reset out_valid", out_valid, 1'b0);
    check_output("reset mem_req", mem_req, 1'b0);
    check32("reset wb_data", wb_data, 32'h0);
    check32("reset mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Backpressure after a load, then simultaneous drain and accept
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 1'b1, 5'd20, 32'h200);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_output("bp mem_req", mem_req, 1'b1);
    mem_rdata = 32'h1122_3344;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    check_output("bp out_valid", out_valid, 1'b1);
    check32("bp wb_data", wb_data, 32'h1122_3344);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("bp hold out_valid", out_valid, 1'b1);
      check32("bp hold wb_data", wb_data, 32'h1122_3344);
      check32("bp hold rd_out", {27'h0, rd_out}, 32'd20);
      check_output("bp hold in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 1'b1, 5'd7, 32'h204);
    #1;
    check_output("bp in_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check_output("bp new out_valid", out_valid, 1'b1);
    check32("bp new wb_data", wb_data, 32'h0000_0055);
    check32("bp new rd_out", {27'h0, rd_out}, 32'd7);
    @(negedge clk);
    check_output("bp drained", out_valid, 1'b0);

    // Ack held high across completion gives exactly one writeback
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0020, 32'h0, 1'b1, 5'd21, 32'h208);
    @(negedge clk);
    in_valid  = 1'b0;
    mem_rdata = 32'hA5A5_0001;
    mem_ack   = 1'b1;
    @(negedge clk);
    check_output("ack2 out_valid", out_valid, 1'b1);
    check32("ack2 wb_data", wb_data, 32'hA5A5_0001);
    @(negedge clk);
    mem_ack = 1'b0;
    check_output("ack2 single", out_valid, 1'b0);
    check_output("ack2 mem_req", mem_req, 1'b0);

    // Reset mid-transaction abandons the access
    drive(1'b1, 1'b0, 3'b010, 32'h0000_0030, 32'h0, 1'b1, 5'd22, 32'h20C);
    @(negedge clk);
    in_valid = 1'b0;
    check_output("rst pre mem_req", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check_output("rst mem_req", mem_req, 1'b0);
    check32("rst mem_addr", mem_addr, 32'h0);
    check_output("rst in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rdata = 32'hFFFF_FFFF;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_output("rst late ack out_valid", out_valid, 1'b0);
    check_output("rst late ack mem_req", mem_req, 1'b0);
    @(negedge clk);
    check_output("rst idle out_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 in_valid  input  1  EXU result bundle valid.
REQ-004 in_ready  output  1  LSU accepts bundle this cycle.
REQ-005 pc  input  32  instruction PC.
REQ-006 rd  input  5  destination register index.
REQ-007 R_wen  input  1  register write enable.
REQ-008 mem_wen  input  1  store instruction.
REQ-009 mem_ren  input  1  load instruction.
REQ-010 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-011 rs2_value  input  32  store data.
REQ-012 EX_result  input  32  ALU result; byte address for loads/stores, writeback data otherwise.
REQ-013 out_valid  output  1  writeback bundle valid.
REQ-014 out_ready  input  1  WBU accepts bundle.
REQ-015 pc_out  output  32  registered pc.
REQ-016 rd_out  output  5  registered rd.
REQ-017 R_wen_out  output  1  registered register write enable.
REQ-018 wb_data  output  32  load data (extended) or EX_result.
REQ-019 misalign  output  1  misaligned access flag for current bundle.
REQ-020 mem_req  output  1  bus request, held until mem_ack.
REQ-021 mem_we  output  1  bus write.
REQ-022 mem_addr  output  32  word-aligned address {EX_result[31:2],2'b00}.
REQ-023 mem_wdata  output  32  store data: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2.
REQ-024 mem_wmask  output  4  byte lanes: SB 4'b0001<<a[1:0], SH 4'b0011<<{a[1],1'b0}, SW 4'b1111.
REQ-025 mem_rdata  input  32  read data, valid when mem_ack=1.
REQ-026 mem_ack  input  1  one-cycle bus completion strobe.

Function
REQ-027 FSM states IDLE, BUS; in_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-028 IDLE, handshake with mem_ren=mem_wen=0: next cycle out_valid=1, wb_data=EX_result, pc/rd/R_wen registered; state stays IDLE (throughput 1/cycle).
REQ-029 IDLE, handshake with mem_ren or mem_wen: next cycle mem_req=1, mem_we=mem_wen, addr/wdata/wmask registered; state -> BUS; out_valid cleared if drained.
REQ-030 BUS: mem_req, mem_we, mem_addr, mem_wdata, mem_wmask SHALL stay stable until mem_ack sampled 1.
REQ-031 BUS with mem_ack=1: next cycle mem_req=0, out_valid=1, state -> IDLE; load wb_data = mem_rdata>>(8*a[1:0]) sign/zero-extended per funct3; store wb_data=EX_result, R_wen_out=0.
REQ-032 Undefined funct3 (011,110,111) SHALL be treated as W.
REQ-033 out_valid held with all out bundle fields stable until out_ready=1; out_valid with out_ready and in_valid in the same cycle SHALL accept the new bundle (no bubble).
REQ-034 mem_ack in IDLE SHALL be ignored; mem_req and mem_ack both asserted never yields two completions.

Reset
REQ-035 rst_n=0 immediately forces state IDLE and all outputs 0 (in_ready follows as 1), including mid-BUS; a pending transaction is abandoned.

Configuration
REQ-036 LSU_MISALIGN_CHECK_EN defined: H with a[0]=1 or W with a[1:0]!=0 issues no bus request; next cycle out_valid=1, misalign=1, R_wen_out=0, wb_data=EX_result.
REQ-037 LSU_MISALIGN_CHECK_EN undefined: misalign tied 0; access issued with lanes per REQ-024 and shift per REQ-031 regardless of alignment.

Verification
REQ-038 ALU op EX_result=0x1234, rd=5, R_wen=1, out_ready=1 -> next cycle out_valid=1, wb_data=0x1234, rd_out=5, no mem_req.
REQ-039 LB addr 0x8000_0003, mem_rdata=0x80FF_FFFF, ack after 3 cycles -> mem_addr=0x8000_0000 stable 3 cycles, wb_data=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-040 SH addr 0x102, rs2=0xABCD_1234 -> mem_we=1, mem_wdata=0x1234_1234, mem_wmask=4'b1100, R_wen_out=0.
REQ-041 out_ready=0 for 4 cycles after load completes -> out_valid and wb_data held, in_ready=0; out_ready=1 with in_valid=1 -> both transfers same cycle.
REQ-042 rst_n pulsed low in BUS with mem_req=1 -> mem_req=0 immediately; later mem_ack=1 -> no out_valid.
REQ-043 LW addr 0x101 with LSU_MISALIGN_CHECK_EN -> no mem_req, misalign=1, R_wen_out=0; without macro -> mem_req=1, misalign=0.
